// File: rtl/mem_responder_512x8.sv
// mem_responder_512x8: wait-stated load/store responder over a 512-byte big-endian array.
// Optional MEM_ALIGN_CHECK_EN: misaligned accesses complete with MSET instead of being force-aligned.
module mem_responder_512x8 #(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        Clk,
  input  logic        Clr,
  input  logic        Enable,
  input  logic [5:0]  OpCode,
  input  logic [31:0] Address,
  input  logic [31:0] DataIn,
  output logic [31:0] DataOut,
  output logic        MFC,
  output logic        MSET
);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BEAT, S_HOLD} state_t;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_D} size_t;

  localparam logic [3:0] LP_WAIT   = 4'(WAIT_CYCLES);
  localparam logic [3:0] LP_RELOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  state_t      r_state, w_next;
  logic [3:0]  r_cnt;
  logic [8:0]  r_addr;
  size_t       r_size, w_size;
  logic        r_store, w_store, r_signed, w_signed, r_misal, w_misal, r_second;
  logic [8:0]  w_addr_in, w_acc_addr;
  logic        w_more, w_go, w_we;
  logic [7:0]  w_b0, w_b1, w_b2, w_b3;
  logic [31:0] w_rdata;
  logic [7:0]  r_mem [0:511];
  logic        w_unused;

  assign w_unused = ^Address[31:9];

  always_comb begin
    w_size   = SZ_W;
    w_store  = 1'b0;
    w_signed = 1'b0;
    case (OpCode)
      6'b000001: w_size = SZ_B;
      6'b000010: w_size = SZ_H;
      6'b000011: w_size = SZ_D;
      6'b000100: w_store = 1'b1;
      6'b000101: begin w_size = SZ_B; w_store = 1'b1; end
      6'b000110: begin w_size = SZ_H; w_store = 1'b1; end
      6'b000111: begin w_size = SZ_D; w_store = 1'b1; end
      6'b001001: begin w_size = SZ_B; w_signed = 1'b1; end
      6'b001010: begin w_size = SZ_H; w_signed = 1'b1; end
      default: ;
    endcase
  end

  always_comb begin
    w_misal   = 1'b0;
    w_addr_in = Address[8:0];
`ifdef MEM_ALIGN_CHECK_EN
    case (w_size)
      SZ_H:    w_misal = Address[0];
      SZ_W:    w_misal = |Address[1:0];
      SZ_D:    w_misal = |Address[2:0];
      default: ;
    endcase
`else
    case (w_size)
      SZ_H:    w_addr_in = {Address[8:1], 1'b0};
      SZ_W:    w_addr_in = {Address[8:2], 2'b00};
      SZ_D:    w_addr_in = {Address[8:3], 3'b000};
      default: ;
    endcase
`endif
  end

  // Second doubleword beat lands WAIT_CYCLES+1 edges after the first; with zero wait states it chains BEAT->BEAT.
  assign w_more     = (r_size == SZ_D) && !r_second && !r_misal;
  assign w_go       = ((r_state == S_WAIT) && (r_cnt == '0)) ||
                      ((r_state == S_BEAT) && w_more && (WAIT_CYCLES == 0));
  assign w_acc_addr = (r_state == S_BEAT) ? r_addr + 9'd4 : r_addr;
  assign w_we       = w_go && r_store && !r_misal && !Clr;

  assign w_b0 = r_mem[w_acc_addr];
  assign w_b1 = r_mem[w_acc_addr + 9'd1];
  assign w_b2 = r_mem[w_acc_addr + 9'd2];
  assign w_b3 = r_mem[w_acc_addr + 9'd3];

  always_comb begin
    case (r_size)
      SZ_B:    w_rdata = {{24{r_signed & w_b0[7]}}, w_b0};
      SZ_H:    w_rdata = {{16{r_signed & w_b0[7]}}, w_b0, w_b1};
      default: w_rdata = {w_b0, w_b1, w_b2, w_b3};
    endcase
  end

  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (Enable) w_next = S_WAIT;
      S_WAIT: if (r_cnt == '0) w_next = S_BEAT;
      S_BEAT: begin
        if (w_more) w_next = (WAIT_CYCLES == 0) ? S_BEAT : S_WAIT;
        else        w_next = S_HOLD;
      end
      S_HOLD: if (!Enable) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    MFC = (r_state == S_BEAT);
`ifdef MEM_ALIGN_CHECK_EN
    MSET = (r_state == S_BEAT) && r_misal;
`else
    MSET = 1'b0;
`endif
  end

  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      r_cnt    <= '0;
      r_addr   <= '0;
      r_size   <= SZ_W;
      r_store  <= 1'b0;
      r_signed <= 1'b0;
      r_misal  <= 1'b0;
      r_second <= 1'b0;
      DataOut  <= '0;
    end else begin
      if (w_go && !r_store && !r_misal) DataOut <= w_rdata;
      case (r_state)
        S_IDLE: if (Enable) begin
          r_addr   <= w_addr_in;
          r_size   <= w_size;
          r_store  <= w_store;
          r_signed <= w_signed;
          r_misal  <= w_misal;
          r_cnt    <= LP_WAIT;
          r_second <= 1'b0;
        end
        S_WAIT: if (r_cnt != '0) r_cnt <= r_cnt - 4'd1;
        S_BEAT: if (w_more) begin
          r_addr   <= r_addr + 9'd4;
          r_cnt    <= LP_RELOAD;
          r_second <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Array has no reset: contents survive Clr.
  always_ff @(posedge Clk) begin
    if (w_we) begin
      case (r_size)
        SZ_B: r_mem[w_acc_addr] <= DataIn[7:0];
        SZ_H: begin
          r_mem[w_acc_addr]        <= DataIn[15:8];
          r_mem[w_acc_addr + 9'd1] <= DataIn[7:0];
        end
        default: begin
          r_mem[w_acc_addr]        <= DataIn[31:24];
          r_mem[w_acc_addr + 9'd1] <= DataIn[23:16];
          r_mem[w_acc_addr + 9'd2] <= DataIn[15:8];
          r_mem[w_acc_addr + 9'd3] <= DataIn[7:0];
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mem_responder_512x8.sv
// Self-checking bench for mem_responder_512x8: directed table, reset/hold sequences, randomized accesses vs a byte-array model.
module tb_mem_responder_512x8;
  localparam int unsigned WC = 2;

  logic        Clk = 1'b0;
  logic        Clr, Enable, MFC, MSET;
  logic [5:0]  OpCode;
  logic [31:0] Address, DataIn, DataOut;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0]  mem_m [512];
  logic [31:0] dout_m;

  typedef struct {
    logic [5:0]  op;
    logic [31:0] addr, d0, d1;
    int          beats;
    logic [31:0] e0, e1;
    logic        ms;
  } vec_t;
  vec_t tbl [18];

  mem_responder_512x8 #(.WAIT_CYCLES(WC)) dut (
    .Clk(Clk), .Clr(Clr), .Enable(Enable), .OpCode(OpCode), .Address(Address),
    .DataIn(DataIn), .DataOut(DataOut), .MFC(MFC), .MSET(MSET)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", nm, act, exp);
    end
  endtask

  function automatic int nbytes(input logic [5:0] op);
    case (op)
      6'h01, 6'h05, 6'h09: return 1;
      6'h02, 6'h06, 6'h0A: return 2;
      6'h03, 6'h07:        return 8;
      default:             return 4;
    endcase
  endfunction

  function automatic bit is_store(input logic [5:0] op);
    return (op >= 6'h04) && (op <= 6'h07);
  endfunction

  function automatic bit is_signed(input logic [5:0] op);
    return (op == 6'h09) || (op == 6'h0A);
  endfunction

  function automatic logic [31:0] rd(input int a, input int n, input bit sgn);
    longint v = 0;
    for (int i = 0; i < n; i++) v = v * 256 + longint'(mem_m[(a + i) % 512]);
    if (sgn && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
    return 32'(v);
  endfunction

  task automatic wr(input int a, input int n, input logic [31:0] d);
    for (int i = 0; i < n; i++) mem_m[(a + i) % 512] = 8'(d >> (8 * (n - 1 - i)));
  endtask

  task automatic model(input logic [5:0] op, input logic [31:0] A, input logic [31:0] d0, input logic [31:0] d1,
                       output int beats, output logic [31:0] e0, output logic [31:0] e1, output logic ms);
    int n, a, per, ab;
    bit fault;
    n = nbytes(op);
    a = int'(A % 512);
    fault = 1'b0;
    ms = 1'b0;
    beats = 1;
    e0 = dout_m;
    e1 = dout_m;
    if (n > 1 && (a % n) != 0) begin
`ifdef MEM_ALIGN_CHECK_EN
      fault = 1'b1;
      ms = 1'b1;
`else
      a = a - (a % n);
`endif
    end
    if (!fault) begin
      per   = (n == 8) ? 4 : n;
      beats = (n == 8) ? 2 : 1;
      for (int b = 0; b < beats; b++) begin
        ab = (a + 4 * b) % 512;
        if (is_store(op)) wr(ab, per, (b == 0) ? d0 : d1);
        else dout_m = rd(ab, per, is_signed(op));
        if (b == 0) e0 = dout_m;
        else        e1 = dout_m;
      end
    end
  endtask

  task automatic run_chk(input string nm, input logic [5:0] op, input logic [31:0] A, input logic [31:0] d0,
                         input logic [31:0] d1, input int beats, input logic [31:0] e0, input logic [31:0] e1,
                         input logic ms);
    int lat, extra;
    @(negedge Clk);
    OpCode = op; Address = A; DataIn = d0; Enable = 1'b1;
    @(posedge Clk);
    for (int b = 0; b < beats; b++) begin
      lat = 0;
      do begin @(posedge Clk); #1; lat++; end while (!MFC && lat < 40);
      chk({nm, " latency"}, 32'(lat), 32'(WC + 1));
      chk({nm, " data"}, DataOut, (b == 0) ? e0 : e1);
      chk({nm, " mset"}, 32'(MSET), 32'(ms));
      if (b == 0) DataIn = d1;
    end
    Enable = 1'b0;
    DataIn = $urandom;
    extra = 0;
    for (int i = 0; i < int'(WC) + 3; i++) begin @(posedge Clk); #1; if (MFC) extra++; end
    chk({nm, " no extra mfc"}, 32'(extra), 32'd0);
  endtask

  task automatic run_model(input string nm, input logic [5:0] op, input logic [31:0] A,
                           input logic [31:0] d0, input logic [31:0] d1);
    int beats;
    logic [31:0] e0, e1;
    logic ms;
    model(op, A, d0, d1, beats, e0, e1, ms);
    run_chk(nm, op, A, d0, d1, beats, e0, e1, ms);
  endtask

  initial begin
    int lat, extra, bx;
    logic [31:0] x0, x1;
    logic xm;
    logic [5:0] ops [12];
    ops = '{6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07, 6'h09, 6'h0A, 6'h3F, 6'h08};

    Clr = 1'b1; Enable = 1'b0; OpCode = '0; Address = '0; DataIn = '0; dout_m = '0;
    repeat (2) @(posedge Clk);
    #1;
    chk("reset MFC", 32'(MFC), 32'd0);
    chk("reset MSET", 32'(MSET), 32'd0);
    chk("reset DataOut", DataOut, 32'h0);
    @(negedge Clk);
    Clr = 1'b0;

    tbl[0]  = '{6'h04, 32'h0000_0010, 32'h1122_3344, 32'h0, 1, 32'h0000_0000, 32'h0, 1'b0};
    tbl[1]  = '{6'h01, 32'h0000_0011, 32'h0, 32'h0, 1, 32'h0000_0022, 32'h0, 1'b0};
    tbl[2]  = '{6'h02, 32'h0000_0012, 32'h0, 32'h0, 1, 32'h0000_3344, 32'h0, 1'b0};
    tbl[3]  = '{6'h00, 32'h0000_0010, 32'h0, 32'h0, 1, 32'h1122_3344, 32'h0, 1'b0};
    tbl[4]  = '{6'h05, 32'h0000_0020, 32'h1234_5680, 32'h0, 1, 32'h1122_3344, 32'h0, 1'b0};
    tbl[5]  = '{6'h09, 32'h0000_0020, 32'h0, 32'h0, 1, 32'hFFFF_FF80, 32'h0, 1'b0};
    tbl[6]  = '{6'h01, 32'h0000_0020, 32'h0, 32'h0, 1, 32'h0000_0080, 32'h0, 1'b0};
    tbl[7]  = '{6'h06, 32'h0000_0022, 32'hDEAD_BEEF, 32'h0, 1, 32'h0000_0080, 32'h0, 1'b0};
    tbl[8]  = '{6'h0A, 32'h0000_0022, 32'h0, 32'h0, 1, 32'hFFFF_BEEF, 32'h0, 1'b0};
    tbl[9]  = '{6'h02, 32'h0000_0022, 32'h0, 32'h0, 1, 32'h0000_BEEF, 32'h0, 1'b0};
    tbl[10] = '{6'h07, 32'h0000_01F8, 32'hAAAA_0001, 32'hBBBB_0002, 2, 32'h0000_BEEF, 32'h0000_BEEF, 1'b0};
    tbl[11] = '{6'h03, 32'h0000_01F8, 32'h0, 32'h0, 2, 32'hAAAA_0001, 32'hBBBB_0002, 1'b0};
    tbl[13] = '{6'h00, 32'h0000_01FC, 32'h0, 32'h0, 1, 32'hBBBB_0002, 32'h0, 1'b0};
    tbl[14] = '{6'h3F, 32'hFFFF_FE10, 32'h0, 32'h0, 1, 32'h1122_3344, 32'h0, 1'b0};
`ifdef MEM_ALIGN_CHECK_EN
    tbl[12] = '{6'h03, 32'h0000_01FC, 32'h0, 32'h0, 1, 32'hBBBB_0002, 32'h0, 1'b1};
    tbl[15] = '{6'h02, 32'h0000_0011, 32'h0, 32'h0, 1, 32'h1122_3344, 32'h0, 1'b1};
    tbl[16] = '{6'h04, 32'h0000_0012, 32'h5566_7788, 32'h0, 1, 32'h1122_3344, 32'h0, 1'b1};
    tbl[17] = '{6'h00, 32'h0000_0010, 32'h0, 32'h0, 1, 32'h1122_3344, 32'h0, 1'b0};
`else
    tbl[12] = '{6'h03, 32'h0000_01FC, 32'h0, 32'h0, 2, 32'hAAAA_0001, 32'hBBBB_0002, 1'b0};
    tbl[15] = '{6'h02, 32'h0000_0011, 32'h0, 32'h0, 1, 32'h0000_1122, 32'h0, 1'b0};
    tbl[16] = '{6'h04, 32'h0000_0012, 32'h5566_7788, 32'h0, 1, 32'h0000_1122, 32'h0, 1'b0};
    tbl[17] = '{6'h00, 32'h0000_0010, 32'h0, 32'h0, 1, 32'h5566_7788, 32'h0, 1'b0};
`endif
    for (int i = 0; i < 18; i++) begin
      model(tbl[i].op, tbl[i].addr, tbl[i].d0, tbl[i].d1, bx, x0, x1, xm);
      run_chk($sformatf("vec%0d", i), tbl[i].op, tbl[i].addr, tbl[i].d0, tbl[i].d1,
              tbl[i].beats, tbl[i].e0, tbl[i].e1, tbl[i].ms);
    end

    // Clr during the wait states of a store: no write, outputs cleared at once.
    @(negedge Clk);
    OpCode = 6'h04; Address = 32'h10; DataIn = 32'hCAFE_F00D; Enable = 1'b1;
    @(posedge Clk);
    @(posedge Clk); #1;
    Clr = 1'b1; #1;
    chk("clr midwait MFC", 32'(MFC), 32'd0);
    chk("clr midwait DataOut", DataOut, 32'h0);
    Enable = 1'b0;
    @(negedge Clk); Clr = 1'b0;
    dout_m = '0;
    run_model("after abort LD", 6'h00, 32'h10, 32'h0, 32'h0);

    // Clr during the beat of a load.
    @(negedge Clk);
    OpCode = 6'h00; Address = 32'h1F8; Enable = 1'b1;
    @(posedge Clk);
    lat = 0;
    do begin @(posedge Clk); #1; lat++; end while (!MFC && lat < 40);
    chk("midbeat latency", 32'(lat), 32'(WC + 1));
    Clr = 1'b1; #1;
    chk("clr midbeat MFC", 32'(MFC), 32'd0);
    chk("clr midbeat DataOut", DataOut, 32'h0);
    Enable = 1'b0;
    @(negedge Clk); Clr = 1'b0;
    dout_m = '0;

    // Enable held high after MFC must not retrigger.
    @(negedge Clk);
    OpCode = 6'h00; Address = 32'h1F8; Enable = 1'b1;
    @(posedge Clk);
    lat = 0;
    do begin @(posedge Clk); #1; lat++; end while (!MFC && lat < 40);
    chk("hold first latency", 32'(lat), 32'(WC + 1));
    chk("hold first data", DataOut, 32'hAAAA_0001);
    extra = 0;
    repeat (10) begin @(posedge Clk); #1; if (MFC) extra++; end
    chk("hold no retrigger", 32'(extra), 32'd0);
    @(negedge Clk); Enable = 1'b0;
    @(negedge Clk); Enable = 1'b1;
    @(posedge Clk);
    lat = 0;
    do begin @(posedge Clk); #1; lat++; end while (!MFC && lat < 40);
    chk("hold rearm latency", 32'(lat), 32'(WC + 1));
    Enable = 1'b0;
    dout_m = 32'hAAAA_0001;
    repeat (3) @(posedge Clk);

    for (int i = 0; i < 128; i++) run_model("init", 6'h04, 32'(i * 4), $urandom, 32'h0);
    for (int i = 0; i < 200; i++)
      run_model($sformatf("rand%0d", i), ops[$urandom_range(0, 11)], $urandom, $urandom, $urandom);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
